// File: rtl/data_mem_arbiter_if.sv
// Data memory arbiter bus: CPU and IO request
// channels plus the single-port memory drive.
// slave  : arbiter side (takes requests, drives
//          grants, rvalid/rdata and memory pins)
// master : requester/memory side
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              io_req;
  logic              io_we;
  logic              io_lock;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_gnt;
  logic              io_rvalid;
  logic [DATA_W-1:0] io_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  io_req, io_we, io_lock,
    input  io_addr, io_wdata,
    output io_gnt, io_rvalid, io_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output io_req, io_we, io_lock,
    output io_addr, io_wdata,
    input  io_gnt, io_rvalid, io_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: CPU priority,
// IO starvation override and IO burst lock.
// Ports: clk, rst (async, active-high),
//        bus (data_mem_arbiter_if.slave).
// Grants and memory pins are combinational;
// rvalid is registered to match 1-cycle reads.
module data_mem_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic {
    ARB,
    IO_BURST
  } state_e;

  localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] burst_q, burst_d;
  logic       cpu_rv_q, cpu_rv_d;
  logic       io_rv_q, io_rv_d;

  logic              cpu_gnt;
  logic              io_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Grants are masked during reset.
  always_comb begin
    cpu_gnt = 1'b0;
    io_gnt  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ARB: begin
          if (bus.io_req &&
              (!bus.cpu_req || wait_q == WAIT_MAX))
            io_gnt = 1'b1;
          else
            cpu_gnt = bus.cpu_req;
        end
        IO_BURST: io_gnt = bus.io_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    unique case (state_q)
      ARB: begin
        // The entering grant is beat 1 of the burst.
        if (io_gnt && bus.io_lock &&
            BURST_MAX > 4'd1) begin
          state_d = IO_BURST;
          burst_d = 4'd1;
        end
      end
      IO_BURST: begin
        if (!bus.io_req || !bus.io_lock ||
            burst_q + 4'd1 >= BURST_MAX) begin
          state_d = ARB;
          burst_d = 4'd0;
        end else begin
          burst_d = burst_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (!bus.io_req || io_gnt)
      wait_d = 4'd0;
    else if (wait_q < WAIT_MAX)
      wait_d = wait_q + 4'd1;
  end

  assign cpu_rv_d = cpu_gnt && !bus.cpu_we;
  assign io_rv_d  = io_gnt && !bus.io_we;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      cpu_gnt: begin
        mem_en    = !bus.cpu_we;
        mem_we    = bus.cpu_we;
        mem_addr  = bus.cpu_addr;
        mem_wdata = bus.cpu_wdata;
      end
      io_gnt: begin
        mem_en    = !bus.io_we;
        mem_we    = bus.io_we;
        mem_addr  = bus.io_addr;
        mem_wdata = bus.io_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB;
      wait_q   <= 4'd0;
      burst_q  <= 4'd0;
      cpu_rv_q <= 1'b0;
      io_rv_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      burst_q  <= burst_d;
      cpu_rv_q <= cpu_rv_d;
      io_rv_q  <= io_rv_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.io_gnt     = io_gnt;
  assign bus.cpu_rvalid = cpu_rv_q;
  assign bus.io_rvalid  = io_rv_q;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.io_rdata   = bus.mem_rdata;
  assign bus.mem_en     = mem_en;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter with a 1-cycle
// registered memory model and read scoreboard.
module tb_data_mem_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .MAX_WAIT(4), .MAX_BURST(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] mem [0:16383];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  typedef struct {
    bit            io;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  localparam logic [DW-1:0] D10 = 32'hDEADBEEF;
  localparam logic [DW-1:0] D20 = 32'hAAAA0020;
  localparam logic [DW-1:0] D30 = 32'hBBBB0030;

  task automatic idle();
    bus.cpu_req = 0; bus.cpu_we = 0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.io_req = 0; bus.io_we = 0; bus.io_lock = 0;
    bus.io_addr = '0; bus.io_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    bd_we = 1; bd_addr = 14'h10; bd_data = D10;
    tick();
    bd_addr = 14'h20; bd_data = D20;
    tick();
    bd_addr = 14'h30; bd_data = D30;
    tick();
    bd_we = 0;
    bus.cpu_req = 1;
    bus.io_req = 1;
    @(negedge clk);
    total++;
    if ({bus.cpu_gnt, bus.io_gnt} !== 2'b00)
      $display("FAIL rst_gnt: got %b want 00",
               {bus.cpu_gnt, bus.io_gnt});
    else passed++;
    total++;
    if ({bus.mem_en, bus.mem_we} !== 2'b00)
      $display("FAIL rst_mem: got %b want 00",
               {bus.mem_en, bus.mem_we});
    else passed++;
    tick();
    rst = 0;
    idle();
    @(negedge clk);
    total++;
    if ({bus.cpu_gnt, bus.io_gnt, bus.cpu_rvalid,
         bus.io_rvalid, bus.mem_en, bus.mem_we} !== 6'b0)
      $display("FAIL idle_ctl: got %b want 000000",
               {bus.cpu_gnt, bus.io_gnt, bus.cpu_rvalid,
                bus.io_rvalid, bus.mem_en, bus.mem_we});
    else passed++;
    total++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== '0)
      $display("FAIL idle_bus: got %h/%h want 0/0",
               bus.mem_addr, bus.mem_wdata);
    else passed++;
  endtask

  task automatic test_cpu_read();
    exp_t e;
    tick();
    bus.cpu_req = 1; bus.cpu_we = 0;
    bus.cpu_addr = 14'h10;
    sb.push_back('{1'b0, D10});
    @(negedge clk);
    total++;
    if ({bus.cpu_gnt, bus.io_gnt, bus.mem_en, bus.mem_we}
        !== 4'b1010)
      $display("FAIL rd_gnt: got %b want 1010",
               {bus.cpu_gnt, bus.io_gnt,
                bus.mem_en, bus.mem_we});
    else passed++;
    total++;
    if (bus.mem_addr !== 14'h10)
      $display("FAIL rd_addr: got %h want 0010",
               bus.mem_addr);
    else passed++;
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({bus.cpu_rvalid, bus.io_rvalid} !== 2'b10)
      $display("FAIL rd_rv: got %b want 10",
               {bus.cpu_rvalid, bus.io_rvalid});
    else passed++;
    e = sb.pop_front();
    total++;
    if (bus.cpu_rdata !== e.d)
      $display("FAIL rd_data: got %h want %h",
               bus.cpu_rdata, e.d);
    else passed++;
  endtask

  // Both sides read back-to-back; IO is forced
  // ahead of the CPU on its 5th waiting cycle.
  task automatic test_starvation();
    bit   pc = 0;
    bit   pi = 0;
    exp_t e;
    tick();
    bus.cpu_req = 1; bus.cpu_addr = 14'h20;
    bus.io_req = 1; bus.io_addr = 14'h30;
    for (int c = 0; c < 8; c++) begin
      bit ei;
      ei = (c == 4);
      if (c == 7) idle();
      @(negedge clk);
      total++;
      if ({bus.cpu_rvalid, bus.io_rvalid} !== {pc, pi})
        $display("FAIL starve_rv c%0d: got %b want %b",
                 c, {bus.cpu_rvalid, bus.io_rvalid},
                 {pc, pi});
      else passed++;
      if (pc || pi) begin
        e = sb.pop_front();
        total++;
        if ((pi ? bus.io_rdata : bus.cpu_rdata) !== e.d
            || e.io != pi)
          $display("FAIL starve_data c%0d: got %h want %h",
                   c, pi ? bus.io_rdata : bus.cpu_rdata,
                   e.d);
        else passed++;
      end
      if (c == 7) break;
      total++;
      if ({bus.cpu_gnt, bus.io_gnt} !== {!ei, ei})
        $display("FAIL starve_gnt c%0d: got %b want %b",
                 c, {bus.cpu_gnt, bus.io_gnt}, {!ei, ei});
      else passed++;
      sb.push_back('{ei, ei ? D30 : D20});
      pc = !ei;
      pi = ei;
      tick();
    end
  endtask

  // IO locked writes hold the grant for 8 beats
  // against a pending CPU read, then CPU wins.
  task automatic test_burst();
    bit   pc = 0;
    exp_t e;
    tick();
    for (int c = 0; c < 11; c++) begin
      bit ei;
      bit ec;
      ei = (c < 8);
      ec = (c >= 8 && c < 10);
      if (c < 10) begin
        bus.cpu_req = (c >= 1); bus.cpu_we = 0;
        bus.cpu_addr = 14'h10;
        bus.io_req = 1; bus.io_we = 1; bus.io_lock = 1;
        bus.io_addr = 14'(14'h100 + (c < 8 ? c : 8));
        bus.io_wdata = 32'hB000_0000 | 32'(c < 8 ? c : 8);
      end else begin
        idle();
      end
      @(negedge clk);
      total++;
      if (bus.cpu_rvalid !== pc || bus.io_rvalid !== 1'b0)
        $display("FAIL burst_rv c%0d: got %b%b want %b0",
                 c, bus.cpu_rvalid, bus.io_rvalid, pc);
      else passed++;
      if (pc) begin
        e = sb.pop_front();
        total++;
        if (bus.cpu_rdata !== e.d)
          $display("FAIL burst_data c%0d: got %h want %h",
                   c, bus.cpu_rdata, e.d);
        else passed++;
      end
      total++;
      if ({bus.cpu_gnt, bus.io_gnt, bus.mem_we}
          !== {ec, ei, ei})
        $display("FAIL burst_gnt c%0d: got %b want %b",
                 c, {bus.cpu_gnt, bus.io_gnt, bus.mem_we},
                 {ec, ei, ei});
      else passed++;
      if (ec) sb.push_back('{1'b0, D10});
      pc = ec;
      tick();
    end
    total++;
    if (mem[14'h107] !== 32'hB000_0007)
      $display("FAIL burst_mem: got %h want b0000007",
               mem[14'h107]);
    else passed++;
  endtask

  task automatic test_write_read();
    exp_t e;
    idle();
    bus.io_req = 1; bus.io_we = 1;
    bus.io_addr = 14'h3FFF; bus.io_wdata = 32'h12345678;
    @(negedge clk);
    total++;
    if ({bus.io_gnt, bus.mem_we, bus.mem_en} !== 3'b110)
      $display("FAIL wr_ctl: got %b want 110",
               {bus.io_gnt, bus.mem_we, bus.mem_en});
    else passed++;
    total++;
    if (bus.mem_addr !== 14'h3FFF ||
        bus.mem_wdata !== 32'h12345678)
      $display("FAIL wr_bus: got %h/%h want 3fff/12345678",
               bus.mem_addr, bus.mem_wdata);
    else passed++;
    tick();
    idle();
    bus.cpu_req = 1; bus.cpu_addr = 14'h3FFF;
    sb.push_back('{1'b0, 32'h12345678});
    @(negedge clk);
    total++;
    if ({bus.cpu_gnt, bus.mem_en, bus.io_rvalid} !== 3'b110)
      $display("FAIL wrrd_gnt: got %b want 110",
               {bus.cpu_gnt, bus.mem_en, bus.io_rvalid});
    else passed++;
    tick();
    idle();
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== e.d)
      $display("FAIL wrrd_data: got %b/%h want 1/%h",
               bus.cpu_rvalid, bus.cpu_rdata, e.d);
    else passed++;
  endtask

  task automatic test_reset_mid();
    tick();
    bus.io_req = 1; bus.io_we = 1; bus.io_lock = 1;
    bus.io_addr = 14'h200;
    @(negedge clk);
    tick();
    bus.cpu_req = 1; bus.cpu_addr = 14'h10;
    bus.io_addr = 14'h201;
    @(negedge clk);
    total++;
    if ({bus.cpu_gnt, bus.io_gnt} !== 2'b01)
      $display("FAIL mid_burst: got %b want 01",
               {bus.cpu_gnt, bus.io_gnt});
    else passed++;
    tick();
    rst = 1;
    @(negedge clk);
    total++;
    if ({bus.cpu_gnt, bus.io_gnt, bus.mem_we} !== 3'b000)
      $display("FAIL mid_rst_gnt: got %b want 000",
               {bus.cpu_gnt, bus.io_gnt, bus.mem_we});
    else passed++;
    tick();
    rst = 0;
    idle();
    bus.cpu_req = 1; bus.cpu_addr = 14'h10;
    bus.io_req = 1; bus.io_addr = 14'h30;
    @(negedge clk);
    total++;
    if ({bus.cpu_gnt, bus.io_gnt} !== 2'b10)
      $display("FAIL post_arb: got %b want 10",
               {bus.cpu_gnt, bus.io_gnt});
    else passed++;
    tick();
    rst = 1;
    idle();
    @(negedge clk);
    total++;
    if ({bus.cpu_rvalid, bus.io_rvalid} !== 2'b00)
      $display("FAIL flight_rv: got %b want 00",
               {bus.cpu_rvalid, bus.io_rvalid});
    else passed++;
    tick();
    rst = 0;
    bus.cpu_req = 1; bus.cpu_we = 1;
    bus.io_req = 1; bus.io_we = 1; bus.io_lock = 1;
    for (int c = 0; c < 13; c++) begin
      bit ei;
      ei = (c >= 4 && c < 12);
      bus.cpu_addr = 14'(14'h300 + c);
      bus.io_addr = 14'(14'h400 + c);
      @(negedge clk);
      total++;
      if ({bus.cpu_gnt, bus.io_gnt, bus.cpu_rvalid,
           bus.io_rvalid} !== {!ei, ei, 2'b00})
        $display("FAIL post_seq c%0d: got %b want %b",
                 c, {bus.cpu_gnt, bus.io_gnt,
                     bus.cpu_rvalid, bus.io_rvalid},
                 {!ei, ei, 2'b00});
      else passed++;
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_starvation();
    test_burst();
    test_write_read();
    test_reset_mid();
    total++;
    if (sb.size() != 0)
      $display("FAIL sb_empty: got %0d want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single-port 16K x 32 data memory between the CPU load/store stage and the IO/DMA engine. Fixed CPU priority, with an IO starvation counter that forces an IO grant, and an IO burst lock. Drives the memory's en/we/addr/wdata directly. Returns read data to the requester whose read was issued, with a registered valid, matching the memory's 1-cycle registered read latency.

Parameters:
ADDR_W, 14, word address width (16384 words)
DATA_W, 32, data width
MAX_WAIT, 4, consecutive cycles IO may be refused before it is forced ahead of CPU (1..15)
MAX_BURST, 8, maximum consecutive locked IO grants (1..15)

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous reset, active-high
cpu_req  input  1  CPU access request
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU word address
cpu_wdata  input  DATA_W  CPU write data
cpu_gnt  output  1  CPU access issued this cycle (combinational)
cpu_rvalid  output  1  cpu_rdata valid (registered)
cpu_rdata  output  DATA_W  read data to CPU
io_req  input  1  IO access request
io_we  input  1  1 = write, 0 = read
io_lock  input  1  IO requests to keep the grant next cycle (burst)
io_addr  input  ADDR_W  IO word address
io_wdata  input  DATA_W  IO write data
io_gnt  output  1  IO access issued this cycle (combinational)
io_rvalid  output  1  io_rdata valid (registered)
io_rdata  output  DATA_W  read data to IO
mem_en  output  1  memory read enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid 1 cycle after a read is issued

Behaviour:
- Requester contract: hold req/we/addr/wdata stable until gnt. The access is issued in the gnt cycle. Deassert req or present the next access the following cycle.
- At most one grant per cycle. Never grant without the matching req.
- FSM states: ARB, IO_BURST.
- ARB grant rule:
  - io_gnt when io_req && (!cpu_req || wait_cnt == MAX_WAIT).
  - Otherwise cpu_gnt = cpu_req.
- IO_BURST grant rule: IO has absolute priority. io_gnt = io_req. cpu_gnt = 0.
- Transitions:
  - ARB -> IO_BURST when io_gnt && io_lock && MAX_BURST > 1. burst_cnt <= 1.
  - IO_BURST stays while io_req && io_lock && burst_cnt < MAX_BURST. burst_cnt increments per io_gnt.
  - IO_BURST -> ARB when !io_req, or !io_lock, or the grant that brings burst_cnt to MAX_BURST is issued. burst_cnt <= 0.
- wait_cnt (4 bits):
  - Increments, saturating at MAX_WAIT, each cycle io_req && !io_gnt.
  - Clears on io_gnt or !io_req.
- Memory drive, combinational from the granted requester:
  - mem_en = gnt && !we.
  - mem_we = gnt && we.
  - mem_addr/mem_wdata follow the granted requester.
  - With no grant: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Read return:
  - cpu_rvalid <= cpu_gnt && !cpu_we. io_rvalid <= io_gnt && !io_we.
  - cpu_rdata = io_rdata = mem_rdata (combinational fan-out). Each is meaningful only while its rvalid = 1.
  - Latency: req/gnt cycle N -> rvalid cycle N+1.
  - Writes produce no rvalid. A write and a read to the same address in consecutive cycles are ordered by issue cycle.
- Back-to-back: a new grant may issue in the cycle a prior rvalid is high. Full throughput is 1 access/cycle.
- Reset (async assert, sync deassert by the system):
  - state = ARB, wait_cnt = 0, burst_cnt = 0.
  - cpu_rvalid = io_rvalid = 0.
  - Gnts and mem_en/mem_we = 0 while rst = 1.
  - A read in flight at reset assertion yields no rvalid.

Test Plan:
1. Reset then idle: rst pulse, no req -> all gnt/rvalid/mem_en/mem_we = 0, mem_addr = 0.
2. CPU read: cpu_req = 1, cpu_we = 0, cpu_addr = 0x0010 with mem[0x10] = 0xDEADBEEF -> cpu_gnt = 1, mem_en = 1 same cycle; next cycle cpu_rvalid = 1, cpu_rdata = 0xDEADBEEF, io_rvalid = 0.
3. Contention/starvation: cpu_req and io_req held high continuously, MAX_WAIT = 4 -> cpu_gnt for 4 cycles, io_gnt on the 5th, wait_cnt back to 0, CPU regains grant on the 6th.
4. IO burst: io_req = io_lock = 1 for 10 cycles, cpu_req = 1, MAX_BURST = 8 -> io_gnt on 8 consecutive cycles, cpu_gnt = 0 throughout, then one cycle back in ARB (CPU granted).
5. Write then read: IO write 0x12345678 to 0x3FFF, then CPU read of 0x3FFF -> mem_we = 1 with mem_addr = 0x3FFF, then cpu_rvalid with 0x12345678.
6. Reset mid-read and mid-burst: assert rst in the cycle after a CPU read gnt while in IO_BURST -> cpu_rvalid stays 0, state returns to ARB, wait_cnt and burst_cnt = 0 after release.
